// File: rtl/spart_core.sv
// spart_core: UART core with a 16-bit baud generator (16 en pulses per bit), TX/RX FSMs and a 4-register bus.
// Optional build macro SPART_FRAME_ERR_EN enables the RX stop-bit check and the ferr status bit.
module spart_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [15:0] divisor, cnt;
    logic        en;
    logic [7:0]  tx_buf, rx_buf, rd_data;
    logic        ferr;
    logic        wr, rd, wr_tx, rd_rx;

    assign wr    = iocs & ~iorw;
    assign rd    = iocs & iorw;
    assign wr_tx = wr && (ioaddr == 2'b00);
    assign rd_rx = rd && (ioaddr == 2'b00);

    always_comb begin
        case (ioaddr)
            2'b00:   rd_data = rx_buf;
            2'b01:   rd_data = {5'b0, ferr, rda, tbr};
            2'b10:   rd_data = divisor[7:0];
            default: rd_data = divisor[15:8];
        endcase
    end

    assign databus = rd ? rd_data : 8'bz;

    // Baud generator: a divisor write restarts the count from the new value.
    assign en = (cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor <= 16'h0000;
            cnt     <= 16'h0000;
        end else begin
            if (wr && ioaddr == 2'b10) divisor[7:0]  <= databus;
            if (wr && ioaddr == 2'b11) divisor[15:8] <= databus;
            if (wr && ioaddr[1])
                cnt <= ioaddr[0] ? {databus, divisor[7:0]} : {divisor[15:8], databus};
            else if (en)
                cnt <= divisor;
            else
                cnt <= cnt - 16'd1;
        end
    end

    // ---------------- transmitter ----------------
    state_t     tx_state, tx_next;
    logic [3:0] tx_tick;
    logic [2:0] tx_idx;
    logic [7:0] tx_shift;
    logic       tx_bit_done;

    assign tx_bit_done = en && (tx_tick == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:    if (!tbr && en) tx_next = START;
            START:   if (tx_bit_done) tx_next = DATA;
            DATA:    if (tx_bit_done && tx_idx == 3'd7) tx_next = STOP;
            STOP:    if (tx_bit_done) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbr      <= 1'b1;
            tx_buf   <= 8'h00;
            tx_shift <= 8'h00;
            tx_tick  <= 4'd0;
            tx_idx   <= 3'd0;
        end else begin
            if (wr_tx && tbr) begin
                tx_buf <= databus;
                tbr    <= 1'b0;
            end
            if (tx_state == STOP && tx_bit_done) tbr <= 1'b1;
            // IDLE keeps the shifter primed so START begins with the latest buffered byte.
            if (tx_state == IDLE) begin
                tx_tick  <= 4'd0;
                tx_idx   <= 3'd0;
                tx_shift <= tx_buf;
            end else if (en) begin
                tx_tick <= tx_tick + 4'd1;
                if (tx_bit_done && tx_state == DATA) begin
                    tx_idx   <= tx_idx + 3'd1;
                    tx_shift <= {1'b0, tx_shift[7:1]};
                end
            end
        end
    end

    assign txd = (tx_state == START) ? 1'b0 :
                 (tx_state == DATA)  ? tx_shift[0] : 1'b1;

    // ---------------- receiver ----------------
    state_t     rx_state, rx_next;
    logic       rx_s1, rx_s2, rx_prev;
    logic [3:0] rx_tick;
    logic [2:0] rx_idx;
    logic [7:0] rx_shift;
    logic       rx_mid, rx_bit_done, rx_load;
`ifdef SPART_FRAME_ERR_EN
    logic       rx_ferr;
`endif

    assign rx_mid      = en && (rx_tick == 4'd7);
    assign rx_bit_done = en && (rx_tick == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= IDLE;
        else     rx_state <= rx_next;
    end

    // Returns to IDLE at mid-stop so a back-to-back start edge is not missed.
    always_comb begin
        rx_next = rx_state;
        rx_load = 1'b0;
`ifdef SPART_FRAME_ERR_EN
        rx_ferr = 1'b0;
`endif
        case (rx_state)
            IDLE:  if (rx_prev && !rx_s2) rx_next = IDLE == IDLE ? START : IDLE;
            START: begin
                if (rx_mid && rx_s2)   rx_next = IDLE;
                else if (rx_bit_done)  rx_next = DATA;
            end
            DATA:  if (rx_bit_done && rx_idx == 3'd7) rx_next = STOP;
            STOP:  if (rx_mid) begin
                rx_next = IDLE;
`ifdef SPART_FRAME_ERR_EN
                if (rx_s2) rx_load = 1'b1;
                else       rx_ferr = 1'b1;
`else
                rx_load = 1'b1;
`endif
            end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_tick  <= 4'd0;
            rx_idx   <= 3'd0;
            rx_shift <= 8'h00;
            rx_buf   <= 8'h00;
            rda      <= 1'b0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_state == IDLE) begin
                rx_tick <= 4'd0;
                rx_idx  <= 3'd0;
            end else if (en) begin
                rx_tick <= rx_tick + 4'd1;
                if (rx_state == DATA && rx_mid)      rx_shift <= {rx_s2, rx_shift[7:1]};
                if (rx_state == DATA && rx_bit_done) rx_idx   <= rx_idx + 3'd1;
            end
            // A completing byte beats a simultaneous buffer read.
            if (rx_load) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
            end else if (rd_rx) begin
                rda <= 1'b0;
            end
        end
    end

`ifdef SPART_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)                             ferr <= 1'b0;
        else if (rx_ferr)                    ferr <= 1'b1;
        else if (rd && ioaddr == 2'b01)      ferr <= 1'b0;
    end
`else
    assign ferr = 1'b0;
`endif

endmodule

// File: doc/spart_core.md
SPART_CORE -- requirements
Module: spart_core

Interface
REQ-001 The block SHALL have the ports: clk  input  1  single system clock; all logic on its rising edge.
REQ-002 The block SHALL have the ports: rst  input  1  reset; synchronous, active-high.
REQ-003 The block SHALL have the ports: iocs  input  1  chip select; active-high; qualifies every bus access.
REQ-004 The block SHALL have the ports: iorw  input  1  access direction; 1 = read, 0 = write.
REQ-005 The block SHALL have the ports: ioaddr  input  2  register select; 00 = TX/RX buffer, 01 = status, 10 = divisor low byte, 11 = divisor high byte.
REQ-006 The block SHALL have the ports: databus  inout  8  bidirectional data bus to the bus driver.
REQ-007 The block SHALL have the ports: rda  output  1  receive data available.
REQ-008 The block SHALL have the ports: tbr  output  1  transmit buffer ready.
REQ-009 The block SHALL have the ports: txd  output  1  serial transmit line; idles high.
REQ-010 The block SHALL have the ports: rxd  input  1  serial receive line; asynchronous to clk.

Function
REQ-011 databus SHALL be driven only while iocs=1 and iorw=1 (combinational from ioaddr); it SHALL be high-Z otherwise.
REQ-012 Reads SHALL return: addr 00 = RX buffer; addr 01 = {5'b0, ferr, rda, tbr}; addrs 10/11 = divisor low/high byte.
REQ-013 Writes (iocs=1, iorw=0) SHALL capture databus on the clk edge: addr 00 = TX buffer; addr 10/11 = divisor byte; addr 01 = ignored.
REQ-014 The baud generator SHALL be a 16-bit down-counter; it SHALL pulse en for one clk and reload from the divisor when it reaches 0; divisor D gives one en every D+1 clocks (D=0 gives en every clock).
REQ-015 A write to either divisor byte SHALL reload the counter with the new 16-bit value on the following clock.
REQ-016 The frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts 16 en pulses.
REQ-017 The TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 A TX buffer write with tbr=1 SHALL clear tbr on the next clock and move IDLE->START aligned to the next en.
REQ-019 After the stop bit completes, the TX FSM SHALL move STOP->IDLE and set tbr.
REQ-020 A TX buffer write while tbr=0 SHALL be ignored; the byte in flight SHALL be unaffected.
REQ-021 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-022 The RX FSM SHALL have states IDLE, START, DATA, STOP; it SHALL leave IDLE when it sees a synchronized 1->0 transition.
REQ-023 In START, if rxd is high at en count 8 (mid-bit), the RX FSM SHALL treat it as a false start and return to IDLE.
REQ-024 Each data bit SHALL be sampled at en count 8 of its bit period.
REQ-025 At mid-stop the received byte SHALL be loaded into the RX buffer and rda set on the next clock.
REQ-026 A new byte completing while rda=1 SHALL overwrite the RX buffer; rda SHALL stay 1 (no overrun flag).
REQ-027 A read of addr 00 SHALL clear rda on the next clock.
REQ-028 If a read of addr 00 and a new byte completion occur in the same cycle, the new byte SHALL win and rda SHALL remain 1.

Reset
REQ-029 While rst=1 on a clk edge, the block SHALL set txd=1, tbr=1, rda=0, ferr=0, RX buffer=0x00, TX buffer=0x00, divisor=0x0000, counter=0x0000, and both FSMs to IDLE.
REQ-030 An rst asserted mid-frame SHALL abort both frames with no partial RX buffer update, and txd SHALL be high on the first clock after reset.

Configuration
REQ-031 With SPART_FRAME_ERR_EN defined, a stop bit sampled as 0 SHALL discard the byte (RX buffer and rda unchanged) and set ferr.
REQ-032 With SPART_FRAME_ERR_EN defined, ferr SHALL clear on the clock after a status (addr 01) read.
REQ-033 Without SPART_FRAME_ERR_EN, the stop bit SHALL not be checked, the byte SHALL always be loaded, and status bit 2 SHALL read 0.

Verification
REQ-034 The bench SHALL cover: divisor write 0x04/0x00 -> en every 5 clocks; bit period 80 clocks.
REQ-035 The bench SHALL cover: divisor 0x0004, write 0x55 to addr 00 -> tbr low next clock; txd = 0,1,0,1,0,1,0,1,0,1, each bit 80 clocks; tbr high after 800 clocks.
REQ-036 The bench SHALL cover: txd looped to rxd, send 0xA3 -> rda=1; addr 00 read returns 0xA3; rda=0 the next clock.
REQ-037 The bench SHALL cover: write 0x11 then 0x22 while tbr=0 -> only 0x11 is transmitted.
REQ-038 The bench SHALL cover: a 0-pulse on rxd of 3 en periods -> false start; rda stays 0.
REQ-039 The bench SHALL cover: with SPART_FRAME_ERR_EN, frame 0x3C with stop bit=0 -> status reads 0x05 (ferr=1, rda=0, tbr=1), then 0x01 on the next status read.
